// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Request/response bundle between the EX-stage decode and the iterative
//   RV32M multiply/divide sequencer.
//
//   start   request a new operation (honoured only while idle)
//   flush   abort the operation in flight
//   Funct3  operation select, sampled with start
//   op_a    rs1 value, sampled with start
//   op_b    rs2 value, sampled with start
//   result  final result, held until the next done
//   busy    high whenever an operation is in flight (front-end stall)
//   done    one-cycle pulse marking result valid
//
//   master: the requester (decode / testbench)
//   slave : the sequencer
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, flush, Funct3, op_a, op_b,
        input  result, busy, done
    );

    modport slave (
        input  start, flush, Funct3, op_a, op_b,
        output result, busy, done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide controller. One shared shift/add-subtract
//   datapath is stepped WIDTH times per operation:
//     IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE
//   Operands are converted to magnitudes in PREP; signs are reapplied in FIX.
//   Divide-by-zero follows the RISC-V rules; signed overflow falls out of the
//   magnitude datapath with no special case.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    muldiv_sequencer_if.slave (start, flush, Funct3, op_a, op_b in;
//          result, busy, done out)
//
// Optional build macro
//   MDU_FAST_ZERO_EN  when defined, an operation with a zero operand skips CALC
//                     (PREP -> FIX -> DONE); results are unchanged.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [2:0]         fn;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] acc;
    logic               sa;
    logic               sb;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   result_reg;
    logic               busy_reg;
    logic               done_reg;

    // Operation class and which operands are treated as signed.
    // Multiply: MUL/MULH both signed, MULHSU only op_a, MULHU neither.
    // Divide: DIV/REM signed, DIVU/REMU unsigned.
    logic is_div;
    logic signed_a;
    logic signed_b;

    assign is_div   = fn[2];
    assign signed_a = is_div ? ~fn[0] : (fn[1:0] != 2'b11);
    assign signed_b = is_div ? ~fn[0] : ~fn[1];

    // One datapath step.
    // Multiply: a_abs is the multiplier shifted out LSB-first; the partial
    // sum is added into the top half and the whole product shifts right.
    // Divide: a_abs is the dividend shifted out MSB-first while quotient bits
    // shift in behind it; acc[WIDTH-1:0] holds the running remainder. The
    // extra top bit of div_diff is the borrow of the trial subtraction.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (a_abs[0] ? {1'b0, b_abs} : '0);
    assign div_shift = {acc[WIDTH-1:0], a_abs[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, b_abs};

    // Sign correction and output selection used in FIX. A zero divisor
    // overrides the sign logic: quotient all ones, remainder = op_a.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_value;

    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quot_fix = (sa ^ sb) ? -a_abs : a_abs;
    assign rem_fix  = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_comb begin
        fix_value = '0;
        case (fn)
            3'b000:                 fix_value = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_value = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_value = (b_reg == '0) ? '1 : quot_fix;
            default:                fix_value = (b_reg == '0) ? a_reg : rem_fix;
        endcase
    end

    // Sequencer FSM. All outputs are registered here; busy tracks
    // state != IDLE one-for-one. flush pre-empts everything outside IDLE
    // and in IDLE it masks a coincident start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fn         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            a_abs      <= '0;
            b_abs      <= '0;
            acc        <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            cnt        <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (bus.flush && state != IDLE) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        fn       <= bus.Funct3;
                        a_reg    <= bus.op_a;
                        b_reg    <= bus.op_b;
                        busy_reg <= 1'b1;
                        state    <= PREP;
                    end
                end

                PREP: begin
                    sa    <= signed_a & a_reg[WIDTH-1];
                    sb    <= signed_b & b_reg[WIDTH-1];
                    a_abs <= (signed_a & a_reg[WIDTH-1]) ? -a_reg : a_reg;
                    b_abs <= (signed_b & b_reg[WIDTH-1]) ? -b_reg : b_reg;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH - 1);
`ifdef MDU_FAST_ZERO_EN
                    // A zero operand leaves acc and a_abs already holding the
                    // final product/quotient/remainder magnitudes (all zero).
                    if (a_reg == '0 || b_reg == '0) begin
                        state <= FIX;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                end

                CALC: begin
                    if (!is_div) begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        a_abs <= a_abs >> 1;
                    end else if (!div_diff[WIDTH+1]) begin
                        acc   <= {{WIDTH{1'b0}}, div_diff[WIDTH-1:0]};
                        a_abs <= {a_abs[WIDTH-2:0], 1'b1};
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, div_shift[WIDTH-1:0]};
                        a_abs <= {a_abs[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                FIX: begin
                    result_reg <= fix_value;
                    done_reg   <= 1'b1;
                    state      <= DONE;
                end

                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer. The driver computes each expected
//   result from RV32M arithmetic on 64-bit integers and queues it together
//   with the expected done timing; an independent monitor pops an entry on
//   every done pulse and compares result, latency and busy duration. It also
//   watches that result never changes without done and that busy drops
//   right after done.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count of rising edges; read only on falling edges.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] res;
        int           start_edge;
        int           lat;
        string        name;
    } sb_t;

    sb_t sb_q[$];

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int last_start;
    int op_idx   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RV32M reference semantics.
    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint       sa_v = longint'($signed(a));
        longint       sb_v = longint'($signed(b));
        longint       ua_v = longint'({32'b0, a});
        longint       ub_v = longint'({32'b0, b});
        logic [63:0]  p;
        case (f)
            3'd0: begin p = sa_v * sb_v; return p[31:0];  end
            3'd1: begin p = sa_v * sb_v; return p[63:32]; end
            3'd2: begin p = sa_v * ub_v; return p[63:32]; end
            3'd3: begin p = ua_v * ub_v; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                p = sa_v / sb_v;
                return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa_v % sb_v;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int expected_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_FAST_ZERO_EN
        if (a == 0 || b == 0) return 2;
`endif
        return W + 2;
    endfunction

    // Issue one request from a falling edge while idle; returns on the
    // falling edge of cycle 1 with last_start = edge count of edge 0.
    task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit expect_done);
        sb_t e;
        bus.Funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        last_start = edge_cnt;
        op_idx++;
        if (expect_done) begin
            e.res        = ref_model(f, a, b);
            e.start_edge = last_start;
            e.lat        = expected_lat(a, b);
            e.name       = $sformatf("op%0d_f%0d_a%0h_b%0h", op_idx, f, a, b);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < W + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", bus.busy, 0);
    endtask

    task automatic wait_cycle(input int k);
        while (edge_cnt < last_start + k - 1) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        int           busy_run  = 0;
        logic [W-1:0] prev_res  = '0;
        bit           prev_done = 1'b0;
        sb_t          e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run  = 0;
                prev_res  = bus.result;
                prev_done = 1'b0;
            end else begin
                busy_run = bus.busy ? busy_run + 1 : 0;
                if (prev_done) checkOutput("busy_after_done", bus.busy, 0);
                if (bus.done) begin
                    done_cnt++;
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput({e.name, "_result"}, bus.result, e.res);
                        checkOutput({e.name, "_latency"}, edge_cnt - e.start_edge, e.lat);
                        checkOutput({e.name, "_busy_cycles"}, busy_run, e.lat + 1);
                    end
                end else begin
                    checkOutput("result_stable", bus.result, prev_res);
                end
                prev_res  = bus.result;
                prev_done = bus.done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t directed[$];

    initial begin
        logic [W-1:0] held;
        int           dones_before;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.Funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_result", bus.result, 0);
        reset = 1'b0;
        @(negedge clk);

        directed.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD});
        directed.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000});
        directed.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        directed.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2});
        directed.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2});
        directed.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2});
        directed.push_back('{3'd5, 32'd100,       32'd7});
        directed.push_back('{3'd7, 32'd100,       32'd7});
        directed.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF});
        directed.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF});
        directed.push_back('{3'd5, 32'd5,         32'd0});
        directed.push_back('{3'd6, 32'd5,         32'd0});
        directed.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0});
        directed.push_back('{3'd0, 32'd0,         32'd12345});
        foreach (directed[i]) begin
            applyStimulus(directed[i].f, directed[i].a, directed[i].b, 1'b1);
            wait_idle();
        end

        // start re-pulsed mid-operation with different operands
        applyStimulus(3'd5, 32'd100, 32'd7, 1'b1);
        wait_cycle(10);
        bus.Funct3 = 3'd0;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd9;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_idle();

        // flush at cycle 12: idle at 13, no done, result unchanged
        held         = bus.result;
        dones_before = done_cnt;
        applyStimulus(3'd0, 32'd11, 32'd13, 1'b0);
        wait_cycle(12);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush_busy", bus.busy, 0);
        checkOutput("flush_result", bus.result, held);
        repeat (W + 5) @(negedge clk);
        checkOutput("flush_no_done", done_cnt, dones_before);

        // flush in IDLE masks start
        bus.Funct3 = 3'd0;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        checkOutput("idle_flush_blocks_start", bus.busy, 0);

        // reset at cycle 20 of a DIV
        dones_before = done_cnt;
        applyStimulus(3'd4, 32'd1000, 32'd3, 1'b0);
        wait_cycle(20);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midop_reset_busy", bus.busy, 0);
        checkOutput("midop_reset_done", bus.done, 0);
        checkOutput("midop_reset_result", bus.result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midop_reset_no_done", done_cnt, dones_before);
        applyStimulus(3'd0, 32'd3, 32'd4, 1'b1);
        wait_idle();

        // randomized traffic, back-to-back on the first idle cycle
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
